// File: rtl/bpu_inst_fetch.sv
// Instruction fetch unit: IDLE/RUN/HOLD fetch FSM that streams reads into
// a 1-cycle-latency instruction SRAM and queues the returned words, each
// paired with its address, in a small prefetch FIFO for the controller.
// Each read is presented in cycle N, its data arrives in cycle N+1, and the
// entry becomes visible at the FIFO head in cycle N+2.
// Optional feature: define IFU_PERF_CNT_EN to add the stall_cnt output, which
// counts cycles spent in RUN with an empty FIFO.
module bpu_inst_fetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  output logic [AW-1:0] inst_addr,
  output logic          inst_cen,
  output logic          inst_wen,
  input  logic [15:0]   inst_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  output logic [15:0]   inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_addr;
  logic          r_cen;
  logic          r_inflight;   // read data arrives on inst_rdata this cycle
  logic [AW-1:0] r_rd_pc;      // address belonging to that arriving data

  logic [15:0]   r_mem_inst [DEPTH];
  logic [AW-1:0] r_mem_pc   [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_start_acc;
  logic [AW-1:0] w_pc_base;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_pending;
  logic [CW-1:0] w_count_nx;
  logic          w_issue;

  assign w_valid     = (r_count != '0);
  assign w_start_acc = start && (r_state == S_IDLE) && !redirect;
  assign w_pc_base   = redirect ? redirect_pc : (w_start_acc ? '0 : r_fetch_pc);
  // Data of a read that overlaps a redirect is dropped rather than queued.
  assign w_push      = r_inflight && !redirect;
  assign w_pop       = w_valid && inst_ready;
  // The read presented this cycle will still need a slot after this edge.
  assign w_pending   = !r_cen && !redirect;
  assign w_count_nx  = redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  // A new read must fit alongside everything already queued or outstanding.
  assign w_issue     = (w_state_nx == S_RUN) &&
                       (({1'b0, w_count_nx} + (CW+1)'(w_pending)) < LIMIT);

  // Next-state decode; redirect overrides every state.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nx and no latch is inferred.
    w_state_nx = r_state;
    if (redirect) begin
      w_state_nx = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nx = S_RUN;
        S_RUN:   if (halt)  w_state_nx = S_HOLD;
        S_HOLD:  if (!halt) w_state_nx = S_RUN;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // FSM, fetch PC and registered SRAM request; also tracks the outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_addr     <= '0;
      r_cen      <= 1'b1;
      r_inflight <= 1'b0;
      r_rd_pc    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_inflight <= w_pending;
      r_rd_pc    <= r_addr;
      r_cen      <= !w_issue;
      if (w_issue) begin
        r_addr     <= w_pc_base;
        r_fetch_pc <= w_pc_base + AW'(1);
      end else begin
        r_fetch_pc <= w_pc_base;
      end
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nx;
    end
  end

  // FIFO storage: returned instruction plus the address it was fetched from.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only observed through the count, which is.
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= inst_rdata;
      r_mem_pc[r_wr_ptr]   <= r_rd_pc;
    end
  end

  assign inst_addr  = r_addr;
  assign inst_cen   = r_cen;
  assign inst_wen   = 1'b1;
  assign inst_valid = w_valid;
  assign inst       = w_valid ? r_mem_inst[r_rd_ptr] : '0;
  assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;

`ifdef IFU_PERF_CNT_EN
  // Stall counter: cycles in RUN with nothing for the controller, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (w_start_acc) begin
      stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !w_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_inst_fetch.sv
// Bench for bpu_inst_fetch: directed scenarios push the expected
// instruction stream into a queue; a monitor pops and compares on every
// accepted handshake. Cycle-exact checks go through check().
module tb_bpu_inst_fetch;

  localparam int AW = 11;

  typedef struct packed {
    logic [15:0]   inst;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, halt, redirect, inst_ready;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] inst_addr;
  logic          inst_cen, inst_wen;
  logic [15:0]   inst_rdata = '0;
  logic          inst_valid;
  logic [15:0]   inst;
  logic [AW-1:0] inst_pc;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bpu_inst_fetch #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .inst_addr(inst_addr), .inst_cen(inst_cen), .inst_wen(inst_wen),
    .inst_rdata(inst_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // SRAM contents: four fixed words, then a pattern derived from the address.
  function automatic logic [15:0] sram_val(input logic [AW-1:0] a);
    case (a)
      11'd0:   return 16'h0800;
      11'd1:   return 16'h0901;
      11'd2:   return 16'h1A02;
      11'd3:   return 16'h3003;
      default: return 16'hC000 ^ {5'b0, a};
    endcase
  endfunction

  // One-cycle read latency SRAM model.
  always @(posedge clk) begin
    if (!inst_cen) inst_rdata <= sram_val(inst_addr);
  end

  // Monitor: every accepted head entry must match the next expected one.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got inst=%h pc=%h with nothing expected", inst, inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc) begin
          errors++;
          $display("FAIL pop got inst=%h pc=%h want inst=%h pc=%h", inst, inst_pc, e.inst, e.pc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [AW-1:0] first, input int n);
    logic [AW-1:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{inst: sram_val(p), pc: p});
      p = p + AW'(1);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0; halt = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    redirect_pc = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic check_q_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int nreads;
    rst = 1'b1;
    start = 1'b0; halt = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    redirect_pc = '0;
    cyc();
    cyc();
    check("rst_cen", 32'(inst_cen), 32'd1);
    check("rst_wen", 32'(inst_wen), 32'd1);
    check("rst_addr", 32'(inst_addr), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_pc", 32'(inst_pc), 32'd0);
    rst = 1'b0;
    cyc();

    // Basic stream: first read in cycle 1, first word valid in cycle 3,
    // then one per cycle; a second start while running is ignored.
    expect_seq(11'd0, 8);
    inst_ready = 1'b1;
    start = 1'b1;                                   // cycle 0
    cyc(); start = 1'b0;                            // cycle 1
    check("t1_c1_cen", 32'(inst_cen), 32'd0);
    check("t1_c1_addr", 32'(inst_addr), 32'd0);
    cyc();                                          // cycle 2
    check("t1_c2_valid", 32'(inst_valid), 32'd0);
    cyc();                                          // cycle 3
    check("t1_c3_valid", 32'(inst_valid), 32'd1);
    check("t1_c3_inst", 32'(inst), 32'h0800);
    check("t1_c3_pc", 32'(inst_pc), 32'd0);
    for (int c = 4; c <= 10; c++) begin
      cyc();
      start = (c == 5);
      check("t1_stream_valid", 32'(inst_valid), 32'd1);
    end
    cyc(); start = 1'b0; inst_ready = 1'b0;         // cycle 11
    check_q_empty("t1_drained");

    // Back-pressure: exactly four reads, head held, resume at address 4.
    reset_dut();
    expect_seq(11'd0, 8);
    nreads = 0;
    start = 1'b1;                                   // cycle 0
    for (int c = 1; c <= 10; c++) begin
      cyc();
      start = 1'b0;
      if (!inst_cen) nreads++;
      if (c >= 3) begin
        check("t2_hold_valid", 32'(inst_valid), 32'd1);
        check("t2_hold_inst", 32'(inst), 32'h0800);
      end
    end
    check("t2_nreads", 32'(nreads), 32'd4);
    cyc(); inst_ready = 1'b1;                       // cycle 11
    check("t2_c11_cen", 32'(inst_cen), 32'd1);
    cyc();                                          // cycle 12
    check("t2_resume_cen", 32'(inst_cen), 32'd0);
    check("t2_resume_addr", 32'(inst_addr), 32'd4);
    for (int c = 13; c <= 18; c++) cyc();
    cyc(); inst_ready = 1'b0;                       // cycle 19
    check_q_empty("t2_drained");

    // Redirect to 0x010 while the read of address 5 is outstanding; the pop
    // in the redirect cycle still counts.
    reset_dut();
    expect_seq(11'd0, 4);
    expect_seq(11'h010, 4);
    inst_ready = 1'b1;
    start = 1'b1;                                   // cycle 0
    cyc(); start = 1'b0;                            // cycle 1
    for (int c = 2; c <= 6; c++) cyc();             // cycle 6
    check("t3_c6_cen", 32'(inst_cen), 32'd0);
    check("t3_c6_addr", 32'(inst_addr), 32'd5);
    redirect = 1'b1; redirect_pc = 11'h010;
    cyc(); redirect = 1'b0;                         // cycle 7
    check("t3_flush_valid", 32'(inst_valid), 32'd0);
    check("t3_new_cen", 32'(inst_cen), 32'd0);
    check("t3_new_addr", 32'(inst_addr), 32'h010);
    cyc();                                          // cycle 8
    check("t3_c8_valid", 32'(inst_valid), 32'd0);
    check("t3_c8_addr", 32'(inst_addr), 32'h011);
    cyc();                                          // cycle 9
    check("t3_c9_pc", 32'(inst_pc), 32'h010);
    for (int c = 10; c <= 12; c++) cyc();
    cyc(); inst_ready = 1'b0;                       // cycle 13
    check_q_empty("t3_drained");

    // Redirect from IDLE to the top address: fetch wraps to zero.
    reset_dut();
    expect_seq(11'h7FF, 4);
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 11'h7FF;         // cycle 0
    cyc(); redirect = 1'b0;                         // cycle 1
    check("t4_c1_cen", 32'(inst_cen), 32'd0);
    check("t4_c1_addr", 32'(inst_addr), 32'h7FF);
    cyc();                                          // cycle 2
    check("t4_wrap_addr", 32'(inst_addr), 32'h000);
    cyc();                                          // cycle 3
    check("t4_c3_pc", 32'(inst_pc), 32'h7FF);
    for (int c = 4; c <= 6; c++) cyc();
    cyc(); inst_ready = 1'b0;                       // cycle 7
    check_q_empty("t4_drained");

    // Halt with two entries queued: no reads, entries still pop, resume at 2.
    reset_dut();
    expect_seq(11'd0, 4);
    start = 1'b1;                                   // cycle 0
    cyc(); start = 1'b0;                            // cycle 1
    cyc(); halt = 1'b1;                             // cycle 2
    cyc();                                          // cycle 3
    check("t5_c3_cen", 32'(inst_cen), 32'd1);
    cyc();                                          // cycle 4
    check("t5_c4_cen", 32'(inst_cen), 32'd1);
    check("t5_c4_valid", 32'(inst_valid), 32'd1);
    check("t5_c4_inst", 32'(inst), 32'h0800);
    cyc(); inst_ready = 1'b1;                       // cycle 5
    check("t5_c5_cen", 32'(inst_cen), 32'd1);
    cyc();                                          // cycle 6
    check("t5_c6_cen", 32'(inst_cen), 32'd1);
    check("t5_c6_pc", 32'(inst_pc), 32'd1);
    cyc(); halt = 1'b0;                             // cycle 7
    check("t5_c7_cen", 32'(inst_cen), 32'd1);
    check("t5_c7_valid", 32'(inst_valid), 32'd0);
    cyc();                                          // cycle 8
    check("t5_resume_cen", 32'(inst_cen), 32'd0);
    check("t5_resume_addr", 32'(inst_addr), 32'd2);
    for (int c = 9; c <= 11; c++) cyc();
    cyc(); inst_ready = 1'b0;                       // cycle 12
    check_q_empty("t5_drained");

    // Reset with a busy FIFO and data in flight, then a clean restart.
    reset_dut();
    start = 1'b1;                                   // cycle 0
    cyc(); start = 1'b0;                            // cycle 1
    for (int c = 2; c <= 5; c++) cyc();             // cycle 5
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    check("t6_pre_addr", 32'(inst_addr), 32'd3);
    rst = 1'b1;
    #1;
    check("t6_rst_cen", 32'(inst_cen), 32'd1);
    check("t6_rst_addr", 32'(inst_addr), 32'd0);
    check("t6_rst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_inst", 32'(inst), 32'd0);
    check("t6_rst_pc", 32'(inst_pc), 32'd0);
    cyc();
    cyc();
    rst = 1'b0; inst_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      check("t6_idle_valid", 32'(inst_valid), 32'd0);
      check("t6_idle_cen", 32'(inst_cen), 32'd1);
    end
    expect_seq(11'd0, 2);
    start = 1'b1;                                   // cycle 0
    cyc(); start = 1'b0;                            // cycle 1
    for (int c = 2; c <= 4; c++) cyc();
    cyc(); inst_ready = 1'b0;                       // cycle 5
    check_q_empty("t6_drained");

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpu_inst_fetch.md
BPU_INST_FETCH -- requirements
Module: bpu_inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 11, instruction SRAM address width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, pulse that starts fetching from address 0.
REQ-006 SHALL have port halt, input, 1, level that stops new SRAM reads.
REQ-007 SHALL have port inst_addr, output, AW, instruction SRAM address.
REQ-008 SHALL have port inst_cen, output, 1, instruction SRAM chip enable, active-low.
REQ-009 SHALL have port inst_wen, output, 1, instruction SRAM write enable, active-low, tied 1.
REQ-010 SHALL have port inst_rdata, input, 16, instruction SRAM read data.
REQ-011 SHALL have port redirect, input, 1, jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc, input, AW, jump target address.
REQ-013 SHALL have port inst_valid, output, 1, FIFO head is valid.
REQ-014 SHALL have port inst, output, 16, FIFO head instruction.
REQ-015 SHALL have port inst_pc, output, AW, address of FIFO head instruction.
REQ-016 SHALL have port inst_ready, input, 1, controller consumes head.

Function
REQ-017 SHALL implement FSM IDLE, RUN, HOLD: IDLE->RUN on start; RUN->HOLD while halt=1; HOLD->RUN when halt=0; any state->RUN with fetch_pc=redirect_pc on redirect.
REQ-018 inst_addr and inst_cen SHALL be registered outputs; a read is issued in cycle N as inst_cen=0, inst_addr=fetch_pc.
REQ-019 inst_rdata SHALL be valid in cycle N+1 and written into the FIFO at the end of N+1 with its address; inst_valid SHALL go high in N+2.
REQ-020 A read SHALL be issued only in RUN when (FIFO count + in-flight read) < DEPTH; otherwise inst_cen=1.
REQ-021 fetch_pc SHALL increment by 1 per issued read, wrapping from 2^AW-1 to 0.
REQ-022 Handshake: head is popped on a clock edge with inst_valid=1 and inst_ready=1; inst and inst_pc SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-023 inst_valid SHALL equal FIFO non-empty; inst and inst_pc SHALL be the head entry.
REQ-024 Push and pop in the same cycle SHALL both complete, and count SHALL be unchanged.
REQ-025 Sustained throughput SHALL be one instruction per cycle while inst_ready=1 and halt=0.
REQ-026 redirect SHALL flush the FIFO (inst_valid=0 next cycle) and mark any in-flight read killed so that its data is discarded.
REQ-027 A pop coinciding with redirect SHALL be accepted; the flush still applies.
REQ-028 The first read at redirect_pc SHALL issue in the cycle after redirect; redirect in IDLE or HOLD SHALL enter RUN.
REQ-029 start in RUN or HOLD SHALL be ignored.
REQ-030 halt SHALL not flush; in-flight data SHALL still be written, and queued entries SHALL remain poppable.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, fetch_pc 0, FIFO empty, in-flight cleared, inst_cen=1, inst_addr=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 rst asserted mid-read SHALL discard that read; no FIFO write occurs after rst deasserts.

Configuration
REQ-033 With macro IFU_PERF_CNT_EN defined, the block SHALL add output stall_cnt, 16 bits, reset 0, incremented each cycle with state RUN and inst_valid=0, saturating at 0xFFFF, cleared on start.
REQ-034 Without IFU_PERF_CNT_EN, the stall_cnt port and counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, start pulse in cycle 0, inst_ready=1, SRAM[0..3]=0x0800,0x0901,0x1A02,0x3003 -> inst_cen=0 with addr 0 in cycle 1; inst=0x0800, inst_pc=0 valid in cycle 3; then one instruction per cycle in order.
REQ-036 inst_ready=0 after start -> exactly DEPTH=4 reads issued, then inst_cen=1; inst=0x0800 held stable; raising inst_ready resumes reads at addr 4.
REQ-037 redirect=1, redirect_pc=0x010 while a read of addr 5 is in flight -> inst_valid=0 next cycle, addr-5 data never appears, next issued addr is 0x010, and the next valid instruction has inst_pc=0x010.
REQ-038 redirect_pc=0x7FF -> reads issue at 0x7FF then 0x000, and inst_pc sequence is 0x7FF, 0x000.
REQ-039 halt=1 for 5 cycles with FIFO at 2 entries -> no reads issued, both entries poppable; halt=0 -> reads resume at the next sequential address.
REQ-040 rst pulse while FIFO is full and a read is in flight -> all outputs take reset values at once; after rst deasserts, inst_valid stays 0 until a new start.
